// File: rtl/gray_seq_checker.sv
// gray_seq_checker
//   Accepts one Gray-coded sample per cycle and decodes it to binary. It then
//   checks that the sample lies exactly one count step (+1 or -1, modulo
//   2^VEC_W) from the previously accepted sample. It reports the step
//   direction and an error flag, and keeps a saturating count of bad steps.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   valid_i     gray_i carries a sample this cycle
//   gray_i      Gray-coded sample
//   clear_i     synchronous clear of error count and tracking state;
//               a sample presented in the same cycle is discarded
//   valid_o     one-cycle pulse, the result outputs below hold a new result
//   bin_o       binary decode of the last accepted sample
//   step_err_o  high with valid_o when the step was illegal
//   dir_o       direction of the last legal step (1 = up, 0 = down)
//   err_cnt_o   saturating count of illegal steps
module gray_seq_checker #(
    parameter int VEC_W     = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_i,
    input  logic [VEC_W-1:0]     gray_i,
    input  logic                 clear_i,
    output logic                 valid_o,
    output logic [VEC_W-1:0]     bin_o,
    output logic                 step_err_o,
    output logic                 dir_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    localparam logic [VEC_W-1:0]     STEP_ONE = VEC_W'(1);
    localparam logic [ERR_CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [ERR_CNT_W-1:0] CNT_ONE  = ERR_CNT_W'(1);

    typedef enum logic {
        IDLE,   // no reference sample held, next sample is not checked
        TRACK   // prev_bin_reg holds the last accepted sample
    } state_t;

    state_t                 state_reg, state_next;
    logic [VEC_W-1:0]       prev_bin_reg, prev_bin_next;
    logic                   valid_reg, valid_next;
    logic [VEC_W-1:0]       bin_reg, bin_next;
    logic                   step_err_reg, step_err_next;
    logic                   dir_reg, dir_next;
    logic [ERR_CNT_W-1:0]   err_cnt_reg, err_cnt_next;

    logic [VEC_W-1:0]       bin_dec;

    // Each binary bit is the XOR of all Gray bits at and above it. Writing
    // it as a reduction per bit keeps the decode free of a bit-to-bit chain
    // on a single vector.
    genvar gi;
    generate
        for (gi = 0; gi < VEC_W; gi++) begin : g_decode
            assign bin_dec[gi] = ^gray_i[VEC_W-1:gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            prev_bin_reg <= '0;
            valid_reg    <= 1'b0;
            bin_reg      <= '0;
            step_err_reg <= 1'b0;
            dir_reg      <= 1'b1;
            err_cnt_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            prev_bin_reg <= prev_bin_next;
            valid_reg    <= valid_next;
            bin_reg      <= bin_next;
            step_err_reg <= step_err_next;
            dir_reg      <= dir_next;
            err_cnt_reg  <= err_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        prev_bin_next = prev_bin_reg;
        valid_next    = 1'b0;
        bin_next      = bin_reg;
        step_err_next = 1'b0;
        dir_next      = dir_reg;
        err_cnt_next  = err_cnt_reg;

        if (clear_i) begin
            // Clear wins over a simultaneous sample; bin_o and dir_o hold.
            state_next   = IDLE;
            err_cnt_next = '0;
        end else if (valid_i) begin
            valid_next    = 1'b1;
            bin_next      = bin_dec;
            prev_bin_next = bin_dec;
            state_next    = TRACK;
            case (state_reg)
                IDLE: begin
                    // First sample only establishes the reference.
                end
                TRACK: begin
                    // VEC_W-bit arithmetic gives the wrap-around steps
                    // (all-ones <-> 0) for free.
                    if (bin_dec == prev_bin_reg + STEP_ONE) begin
                        dir_next = 1'b1;
                    end else if (bin_dec == prev_bin_reg - STEP_ONE) begin
                        dir_next = 1'b0;
                    end else begin
                        step_err_next = 1'b1;
                        if (err_cnt_reg != CNT_MAX) begin
                            err_cnt_next = err_cnt_reg + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign valid_o    = valid_reg;
    assign bin_o      = bin_reg;
    assign step_err_o = step_err_reg;
    assign dir_o      = dir_reg;
    assign err_cnt_o  = err_cnt_reg;

endmodule

// File: tb/tb_gray_seq_checker.sv
// Testbench for gray_seq_checker. Two instances share one stimulus stream:
// one uses the default 8-bit error counter, the other a 2-bit counter so that
// saturation is reached often. The driver feeds a reference model and pushes
// expected results into a queue. The monitor pops and compares them on the
// falling edge.
module tb_gray_seq_checker;

    localparam int W = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          valid_i = 1'b0;
    logic [W-1:0]  gray_i = '0;
    logic          clear_i = 1'b0;

    logic          valid_o, step_err_o, dir_o;
    logic [W-1:0]  bin_o;
    logic [7:0]    err_cnt_o;

    logic          valid_s, step_err_s, dir_s;
    logic [W-1:0]  bin_s;
    logic [1:0]    err_cnt_s;

    gray_seq_checker #(.VEC_W(W), .ERR_CNT_W(8)) dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .gray_i(gray_i),
        .clear_i(clear_i), .valid_o(valid_o), .bin_o(bin_o),
        .step_err_o(step_err_o), .dir_o(dir_o), .err_cnt_o(err_cnt_o)
    );

    gray_seq_checker #(.VEC_W(W), .ERR_CNT_W(2)) dut_small (
        .clk(clk), .reset(reset), .valid_i(valid_i), .gray_i(gray_i),
        .clear_i(clear_i), .valid_o(valid_s), .bin_o(bin_s),
        .step_err_o(step_err_s), .dir_o(dir_s), .err_cnt_o(err_cnt_s)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int         cyc;
        bit         is_clear;
        logic [3:0] bin;
        bit         err;
        bit         dir;
        int         cnt;
        int         cnt_s;
    } exp_t;

    exp_t q[$];

    // Reference model state, owned by the driver.
    bit         m_track = 0;
    logic [3:0] m_prev  = '0;
    bit         m_dir   = 1;
    int         m_cnt   = 0;
    int         m_cnt_s = 0;

    function automatic logic [3:0] gray2bin(input logic [3:0] g);
        logic [3:0] b;
        b = g;
        for (int s = 1; s < W; s++) b = b ^ (g >> s);
        return b;
    endfunction

    // One clock of stimulus; the expectation is for the following edge.
    task automatic step(input bit v, input logic [3:0] g, input bit c);
        exp_t       e;
        logic [3:0] b;
        logic [3:0] d;
        @(posedge clk);
        #1;
        valid_i = v;
        gray_i  = g;
        clear_i = c;
        if (c) begin
            m_track = 0;
            m_cnt   = 0;
            m_cnt_s = 0;
            e = '{cyc + 1, 1'b1, 4'd0, 1'b0, 1'b0, 0, 0};
            q.push_back(e);
            $display("cyc %0d: clear (valid_i=%0d gray=%b)", cyc + 1, v, g);
        end else if (v) begin
            b = gray2bin(g);
            e = '{cyc + 1, 1'b0, b, 1'b0, 1'b0, 0, 0};
            if (m_track) begin
                d = b - m_prev;
                if (d == 4'd1) m_dir = 1;
                else if (d == 4'd15) m_dir = 0;
                else begin
                    e.err = 1'b1;
                    if (m_cnt < 255) m_cnt++;
                    if (m_cnt_s < 3) m_cnt_s++;
                end
            end
            m_track = 1;
            m_prev  = b;
            e.dir   = m_dir;
            e.cnt   = m_cnt;
            e.cnt_s = m_cnt_s;
            q.push_back(e);
            $display("cyc %0d: sample gray=%b bin=%0d exp err=%0d dir=%0d cnt=%0d cnt_s=%0d",
                     cyc + 1, g, b, e.err, e.dir, e.cnt, e.cnt_s);
        end
    endtask

    // Reset pulse between edges. The outputs must be at reset values at once.
    task automatic reset_pulse();
        @(posedge clk);
        #1;
        valid_i = 0;
        clear_i = 0;
        #1;
        reset = 1;
        #1;
        chk("async_reset_valid",    int'(valid_o),    0);
        chk("async_reset_bin",      int'(bin_o),      0);
        chk("async_reset_step_err", int'(step_err_o), 0);
        chk("async_reset_dir",      int'(dir_o),      1);
        chk("async_reset_cnt",      int'(err_cnt_o),  0);
        chk("async_reset_cnt_s",    int'(err_cnt_s),  0);
        m_track = 0;
        m_prev  = '0;
        m_dir   = 1;
        m_cnt   = 0;
        m_cnt_s = 0;
        $display("cyc %0d: async reset pulse", cyc);
        #4;
        reset = 0;
    endtask

    // Monitor: last reported values, used to check that outputs hold.
    logic [3:0] last_bin   = '0;
    bit         last_dir   = 1;
    int         last_cnt   = 0;
    int         last_cnt_s = 0;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            q.delete();
            last_bin   = '0;
            last_dir   = 1;
            last_cnt   = 0;
            last_cnt_s = 0;
            chk("reset_valid", int'(valid_o),   0);
            chk("reset_dir",   int'(dir_o),     1);
            chk("reset_cnt",   int'(err_cnt_o), 0);
        end else if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            if (e.is_clear) begin
                last_cnt   = 0;
                last_cnt_s = 0;
                chk("clear_valid",    int'(valid_o),    0);
                chk("clear_step_err", int'(step_err_o), 0);
                chk("clear_cnt",      int'(err_cnt_o),  0);
                chk("clear_cnt_s",    int'(err_cnt_s),  0);
                chk("clear_bin_hold", int'(bin_o),      int'(last_bin));
                chk("clear_dir_hold", int'(dir_o),      int'(last_dir));
            end else begin
                chk("valid",    int'(valid_o),    1);
                chk("bin",      int'(bin_o),      int'(e.bin));
                chk("step_err", int'(step_err_o), int'(e.err));
                chk("dir",      int'(dir_o),      int'(e.dir));
                chk("err_cnt",  int'(err_cnt_o),  e.cnt);
                chk("valid_s",  int'(valid_s),    1);
                chk("err_cnt_s", int'(err_cnt_s), e.cnt_s);
                last_bin   = e.bin;
                last_dir   = e.dir;
                last_cnt   = e.cnt;
                last_cnt_s = e.cnt_s;
            end
        end else begin
            chk("idle_valid",    int'(valid_o),    0);
            chk("idle_step_err", int'(step_err_o), 0);
            chk("idle_bin_hold", int'(bin_o),      int'(last_bin));
            chk("idle_dir_hold", int'(dir_o),      int'(last_dir));
            chk("idle_cnt_hold", int'(err_cnt_o),  last_cnt);
            chk("idle_cnt_s_hold", int'(err_cnt_s), last_cnt_s);
        end
    end

    initial begin
        logic [3:0] w;
        logic [3:0] b;
        int         r;

        #27;
        reset = 0;

        // Count up 0..3
        step(1, 4'b0000, 0);
        step(1, 4'b0001, 0);
        step(1, 4'b0011, 0);
        step(1, 4'b0010, 0);
        // Wrap-around both ways
        step(0, 4'b0000, 1);
        step(1, 4'b1000, 0);
        step(1, 4'b0000, 0);
        step(1, 4'b1000, 0);
        // Skip step, then legal step from the updated reference
        step(0, 4'b0000, 1);
        step(1, 4'b0000, 0);
        step(1, 4'b0011, 0);
        step(1, 4'b0010, 0);
        // Repeated sample with idle gaps
        step(0, 4'b0000, 1);
        step(1, 4'b0001, 0);
        repeat (3) step(0, 4'b0000, 0);
        step(1, 4'b0001, 0);
        // Five illegal steps, which saturates the 2-bit counter
        step(0, 4'b0000, 1);
        for (int i = 0; i < 6; i++) begin
            b = 4'(2 * i);
            step(1, b ^ (b >> 1), 0);
        end
        // Clear together with a sample, then an IDLE sample
        step(1, 4'b0110, 1);
        step(1, 4'b0101, 0);
        step(1, 4'b0111, 0);
        // Reset pulse mid-stream, then the first sample is unchecked
        step(1, 4'b0100, 0);
        reset_pulse();
        step(1, 4'b1111, 0);
        step(1, 4'b1101, 0);

        // Random walk with jumps, gaps, clears and resets
        w = 4'd10;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                reset_pulse();
            end else if (r < 7) begin
                step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1);
            end else if (r < 25) begin
                step(0, 4'($urandom_range(0, 15)), 0);
            end else begin
                r = $urandom_range(0, 99);
                if (r < 40) w = w + 4'd1;
                else if (r < 75) w = w - 4'd1;
                else if (r < 85) w = w;
                else w = 4'($urandom_range(0, 15));
                step(1, w ^ (w >> 1), 0);
            end
        end

        repeat (4) step(0, 4'b0000, 0);
        @(posedge clk);
        #1;
        chk("queue_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
